// File: rtl/vx_div_share_ctrl.sv
// vx_div_share_ctrl: shares one iterative divide unit among NUM_REQS ALU blocks.
// Requests are arbitrated into a one-entry elastic stage toward the unit, the
// number of operations in flight is bounded by a credit counter, and tagged
// results are steered back through a one-entry registered output stage.
// Optional feature macro: VX_DIV_SHARE_RR_EN selects round-robin arbitration;
// when undefined the lowest valid index wins and no pointer register exists.
module vx_div_share_ctrl #(
  parameter int unsigned NUM_REQS    = 4,
  parameter int unsigned DATAW       = 64,
  parameter int unsigned MAX_PENDING = 4,
  localparam int unsigned TAGW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int unsigned CNTW = $clog2(MAX_PENDING + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid_in,
  input  logic [NUM_REQS*DATAW-1:0] req_data_in,
  output logic [NUM_REQS-1:0]       req_ready_in,
  output logic                      unit_req_valid,
  output logic [DATAW-1:0]          unit_req_data,
  output logic [TAGW-1:0]           unit_req_tag,
  input  logic                      unit_req_ready,
  input  logic                      unit_rsp_valid,
  input  logic [DATAW-1:0]          unit_rsp_data,
  input  logic [TAGW-1:0]           unit_rsp_tag,
  output logic                      unit_rsp_ready,
  output logic [NUM_REQS-1:0]       rsp_valid_out,
  output logic [DATAW-1:0]          rsp_data_out,
  input  logic [NUM_REQS-1:0]       rsp_ready_out,
  output logic [CNTW-1:0]           pending_count
);

  // Request stage toward the divide unit
  logic                rb_valid;
  logic [DATAW-1:0]    rb_data;
  logic [TAGW-1:0]     rb_tag;

  // Response stage toward the requesters; the one-hot vector doubles as valid
  logic [NUM_REQS-1:0] ob_onehot;
  logic [DATAW-1:0]    ob_data;

  logic [CNTW-1:0]     pend_q;

  logic                stage_can_load;
  logic                credit_ok;
  logic                pick_found;
  logic [TAGW-1:0]     pick_idx;
  logic [TAGW-1:0]     search_start;
  logic [DATAW-1:0]    pick_data;
  logic                grant;
  logic                deliver;
  logic                ob_valid;
  logic [NUM_REQS-1:0] rsp_onehot;

  // First valid requester at or above start, wrapping at NUM_REQS; MSB = found.
  function automatic logic [TAGW:0] first_valid(input logic [NUM_REQS-1:0] valid,
                                                input logic [TAGW-1:0]     start);
    logic                found;
    logic [TAGW-1:0]     sel;
    logic [NUM_REQS-1:0] rot;
    int unsigned         idx;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      idx = 32'(start) + k;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      rot = valid >> idx;
      if (!found && rot[0]) begin
        found = 1'b1;
        sel   = TAGW'(idx);
      end
    end
    return {found, sel};
  endfunction

`ifdef VX_DIV_SHARE_RR_EN
  logic [TAGW-1:0] rr_ptr;

  // Round-robin pointer moves just past the granted requester, holds otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (32'(pick_idx) == NUM_REQS - 1) ? '0 : pick_idx + TAGW'(1);
    end
  end

  assign search_start = rr_ptr;
`else
  assign search_start = '0;
`endif

  assign stage_can_load           = !rb_valid || unit_req_ready;
  assign credit_ok                = pend_q < CNTW'(MAX_PENDING);
  assign {pick_found, pick_idx}   = first_valid(req_valid_in, search_start);
  assign grant                    = pick_found && stage_can_load && credit_ok;
  assign req_ready_in             = grant ? (NUM_REQS'(1) << pick_idx) : '0;

  assign ob_valid                 = |ob_onehot;
  assign deliver                  = |(ob_onehot & rsp_ready_out);
  assign unit_rsp_ready           = !ob_valid || deliver;
  assign rsp_onehot               = NUM_REQS'(1) << unit_rsp_tag;

  // Payload of the selected requester
  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (32'(pick_idx) == i) pick_data = req_data_in[i*DATAW +: DATAW];
    end
  end

  // Elastic request stage: load on grant, drain when the unit accepts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_valid <= 1'b0;
      rb_data  <= '0;
      rb_tag   <= '0;
    end else if (grant) begin
      rb_valid <= 1'b1;
      rb_data  <= pick_data;
      rb_tag   <= pick_idx;
    end else if (unit_req_ready) begin
      rb_valid <= 1'b0;
    end
  end

  // Response stage: drains and refills in the same cycle when the target is ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ob_onehot <= '0;
      ob_data   <= '0;
    end else if (unit_rsp_ready) begin
      if (unit_rsp_valid) begin
        ob_onehot <= rsp_onehot;
        ob_data   <= unit_rsp_data;
      end else begin
        ob_onehot <= '0;
      end
    end
  end

  // Credit counter: accepted requests minus delivered results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else if (grant && !deliver) begin
      pend_q <= pend_q + CNTW'(1);
    end else if (!grant && deliver) begin
      pend_q <= pend_q - CNTW'(1);
    end
  end

`ifndef SYNTHESIS
  // A delivery with nothing outstanding means the unit produced a spurious result
  assert property (@(posedge clk) disable iff (reset)
                   !(deliver && !grant && (pend_q == '0)))
    else $error("pending_count underflow");
`endif

  assign unit_req_valid = rb_valid;
  assign unit_req_data  = rb_data;
  assign unit_req_tag   = rb_tag;
  assign rsp_valid_out  = ob_onehot;
  assign rsp_data_out   = ob_data;
  assign pending_count  = pend_q;

endmodule

// File: tb/tb_vx_div_share_ctrl.sv
// Self-checking bench for vx_div_share_ctrl (NUM_REQS=4, DATAW=64, MAX_PENDING=4).
// Expectations follow VX_DIV_SHARE_RR_EN when it is defined for the build.
module tb_vx_div_share_ctrl;

  localparam int unsigned NUM_REQS    = 4;
  localparam int unsigned DATAW       = 64;
  localparam int unsigned MAX_PENDING = 4;
  localparam int unsigned TAGW        = 2;
  localparam int unsigned CNTW        = 3;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQS-1:0]       req_valid_in;
  logic [NUM_REQS*DATAW-1:0] req_data_in;
  logic [NUM_REQS-1:0]       req_ready_in;
  logic                      unit_req_valid;
  logic [DATAW-1:0]          unit_req_data;
  logic [TAGW-1:0]           unit_req_tag;
  logic                      unit_req_ready;
  logic                      unit_rsp_valid;
  logic [DATAW-1:0]          unit_rsp_data;
  logic [TAGW-1:0]           unit_rsp_tag;
  logic                      unit_rsp_ready;
  logic [NUM_REQS-1:0]       rsp_valid_out;
  logic [DATAW-1:0]          rsp_data_out;
  logic [NUM_REQS-1:0]       rsp_ready_out;
  logic [CNTW-1:0]           pending_count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [TAGW-1:0]  tag;
    logic [DATAW-1:0] data;
  } req_exp_t;

  typedef struct packed {
    logic [NUM_REQS-1:0] onehot;
    logic [DATAW-1:0]    data;
  } rsp_exp_t;

  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];

  vx_div_share_ctrl #(
    .NUM_REQS(NUM_REQS), .DATAW(DATAW), .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_data_in(req_data_in), .req_ready_in(req_ready_in),
    .unit_req_valid(unit_req_valid), .unit_req_data(unit_req_data),
    .unit_req_tag(unit_req_tag), .unit_req_ready(unit_req_ready),
    .unit_rsp_valid(unit_rsp_valid), .unit_rsp_data(unit_rsp_data),
    .unit_rsp_tag(unit_rsp_tag), .unit_rsp_ready(unit_rsp_ready),
    .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out),
    .rsp_ready_out(rsp_ready_out), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every transfer to the unit and every delivered result is popped and compared
  always @(negedge clk) begin
    req_exp_t re;
    rsp_exp_t se;
    if (!reset && unit_req_valid && unit_req_ready) begin
      checks++;
      if (req_q.size() == 0) begin
        errors++;
        $display("FAIL unit_req_xfer: unexpected transfer tag=%0d data=%h, none expected",
                 unit_req_tag, unit_req_data);
      end else begin
        re = req_q.pop_front();
        if (unit_req_tag !== re.tag || unit_req_data !== re.data) begin
          errors++;
          $display("FAIL unit_req_xfer: got tag=%0d data=%h expected tag=%0d data=%h",
                   unit_req_tag, unit_req_data, re.tag, re.data);
        end
      end
    end
    if (!reset && |(rsp_valid_out & rsp_ready_out)) begin
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_deliver: unexpected delivery valid=%b data=%h, none expected",
                 rsp_valid_out, rsp_data_out);
      end else begin
        se = rsp_q.pop_front();
        if (rsp_valid_out !== se.onehot || rsp_data_out !== se.data) begin
          errors++;
          $display("FAIL rsp_deliver: got valid=%b data=%h expected valid=%b data=%h",
                   rsp_valid_out, rsp_data_out, se.onehot, se.data);
        end
      end
    end
  end

  // Time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input int tag, input logic [DATAW-1:0] data);
    req_exp_t e;
    e.tag  = TAGW'(tag);
    e.data = data;
    req_q.push_back(e);
  endtask

  task automatic push_rsp(input logic [NUM_REQS-1:0] onehot, input logic [DATAW-1:0] data);
    rsp_exp_t e;
    e.onehot = onehot;
    e.data   = data;
    rsp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    req_valid_in   = '0;
    req_data_in    = '0;
    unit_req_ready = 1'b0;
    unit_rsp_valid = 1'b0;
    unit_rsp_data  = '0;
    unit_rsp_tag   = '0;
    rsp_ready_out  = '1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Reset values, then the first grant right after release
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    req_valid_in = '1;
    for (int i = 0; i < NUM_REQS; i++) req_data_in[i*DATAW +: DATAW] = 64'h0A00 + 64'(i);
    repeat (2) @(negedge clk);
    checks++; if (unit_req_valid !== 1'b0) begin errors++; $display("FAIL reset_unit_req_valid: got %b expected 0", unit_req_valid); end
    checks++; if (rsp_valid_out !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid_out); end
    checks++; if (pending_count !== '0) begin errors++; $display("FAIL reset_pending: got %0d expected 0", pending_count); end
    checks++; if (unit_req_data !== '0 || unit_req_tag !== '0) begin errors++; $display("FAIL reset_unit_req_payload: got tag=%0d data=%h expected 0/0", unit_req_tag, unit_req_data); end
    checks++; if (rsp_data_out !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data_out); end
    checks++; if (unit_rsp_ready !== 1'b1) begin errors++; $display("FAIL reset_unit_rsp_ready: got %b expected 1", unit_rsp_ready); end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready_in !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready_in); end
    push_req(0, 64'h0A00);
    tick();
    req_valid_in   = '0;
    unit_req_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready_in !== '0) begin errors++; $display("FAIL reset_no_valid_ready: got %b expected 0000", req_ready_in); end
    tick();
    @(negedge clk);
    checks++; if (pending_count !== CNTW'(1) || unit_req_valid !== 1'b0) begin errors++; $display("FAIL reset_after_one: got pend=%0d valid=%b expected 1/0", pending_count, unit_req_valid); end
    tick();
  endtask

  // All requesters valid: four grants fill the credits, then ready stays low
  task automatic test_fill();
    int exp_g;
    apply_reset();
    unit_req_ready = 1'b1;
    req_valid_in   = '1;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NUM_REQS; i++) req_data_in[i*DATAW +: DATAW] = 64'h1000 + 64'(c*16 + i);
`ifdef VX_DIV_SHARE_RR_EN
      exp_g = c;
`else
      exp_g = 0;
`endif
      @(negedge clk);
      checks++; if (req_ready_in !== (NUM_REQS'(1) << exp_g)) begin errors++; $display("FAIL fill_grant%0d: got %b expected %b", c, req_ready_in, NUM_REQS'(1) << exp_g); end
      checks++; if (pending_count !== CNTW'(c)) begin errors++; $display("FAIL fill_pending%0d: got %0d expected %0d", c, pending_count, c); end
      push_req(exp_g, 64'h1000 + 64'(c*16 + exp_g));
      tick();
    end
    @(negedge clk);
    checks++; if (req_ready_in !== '0 || pending_count !== CNTW'(4)) begin errors++; $display("FAIL fill_credit_full: got ready=%b pend=%0d expected 0000/4", req_ready_in, pending_count); end
    tick();
    @(negedge clk);
    checks++; if (unit_req_valid !== 1'b0 || req_ready_in !== '0) begin errors++; $display("FAIL fill_drained: got valid=%b ready=%b expected 0/0000", unit_req_valid, req_ready_in); end
    req_valid_in = '0;
    tick();
  endtask

  // Unit not ready for 5 cycles: the buffered request holds, then transfers once
  task automatic test_stall();
    apply_reset();
    req_valid_in = 4'b0100;
    req_data_in[2*DATAW +: DATAW] = 64'hABCD;
    @(negedge clk);
    checks++; if (req_ready_in !== 4'b0100) begin errors++; $display("FAIL stall_grant: got %b expected 0100", req_ready_in); end
    push_req(2, 64'hABCD);
    tick();
    req_valid_in = 4'b0001;
    req_data_in[0 +: DATAW] = 64'h1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (unit_req_valid !== 1'b1 || unit_req_tag !== 2'd2 || unit_req_data !== 64'hABCD) begin errors++; $display("FAIL stall_hold%0d: got v=%b tag=%0d data=%h expected 1/2/abcd", c, unit_req_valid, unit_req_tag, unit_req_data); end
      checks++; if (req_ready_in !== '0) begin errors++; $display("FAIL stall_no_ready%0d: got %b expected 0000", c, req_ready_in); end
      tick();
    end
    req_valid_in   = '0;
    unit_req_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (unit_req_valid !== 1'b0) begin errors++; $display("FAIL stall_single_xfer: got valid=%b expected 0", unit_req_valid); end
    tick();
  endtask

  // Credit full, freed by delivery; simultaneous accept and delivery keep the count
  task automatic test_credit();
    apply_reset();
    unit_req_ready = 1'b1;
    req_valid_in   = 4'b0010;
    rsp_ready_out  = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      req_data_in[1*DATAW +: DATAW] = 64'h2000 + 64'(c);
      @(negedge clk);
      checks++; if (req_ready_in !== 4'b0010) begin errors++; $display("FAIL credit_grant%0d: got %b expected 0010", c, req_ready_in); end
      push_req(1, 64'h2000 + 64'(c));
      tick();
    end
    req_data_in[1*DATAW +: DATAW] = 64'h2004;
    unit_rsp_valid = 1'b1;
    unit_rsp_tag   = 2'd1;
    unit_rsp_data  = 64'hD1;
    @(negedge clk);
    checks++; if (pending_count !== CNTW'(4) || req_ready_in !== '0) begin errors++; $display("FAIL credit_full: got pend=%0d ready=%b expected 4/0000", pending_count, req_ready_in); end
    checks++; if (unit_rsp_ready !== 1'b1) begin errors++; $display("FAIL credit_rsp_accept1: got %b expected 1", unit_rsp_ready); end
    push_rsp(4'b0010, 64'hD1);
    tick();
    unit_rsp_data = 64'hD2;
    @(negedge clk);
    checks++; if (rsp_valid_out !== 4'b0010) begin errors++; $display("FAIL credit_rsp_valid: got %b expected 0010", rsp_valid_out); end
    checks++; if (pending_count !== CNTW'(4) || req_ready_in !== '0) begin errors++; $display("FAIL credit_no_bypass: got pend=%0d ready=%b expected 4/0000", pending_count, req_ready_in); end
    checks++; if (unit_rsp_ready !== 1'b1) begin errors++; $display("FAIL credit_rsp_accept2: got %b expected 1", unit_rsp_ready); end
    push_rsp(4'b0010, 64'hD2);
    tick();
    unit_rsp_valid = 1'b0;
    @(negedge clk);
    checks++; if (pending_count !== CNTW'(3) || req_ready_in !== 4'b0010) begin errors++; $display("FAIL credit_freed: got pend=%0d ready=%b expected 3/0010", pending_count, req_ready_in); end
    push_req(1, 64'h2004);
    tick();
    req_valid_in = '0;
    @(negedge clk);
    checks++; if (pending_count !== CNTW'(3) || rsp_valid_out !== '0) begin errors++; $display("FAIL credit_inc_dec: got pend=%0d rspv=%b expected 3/0000", pending_count, rsp_valid_out); end
    tick();
  endtask

  // Results 3,0,3 with requester 3 stalled for two cycles
  task automatic test_back_to_back();
    int order[3] = '{3, 0, 3};
    apply_reset();
    unit_req_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req_valid_in = NUM_REQS'(1) << order[c];
      req_data_in  = '0;
      req_data_in[order[c]*DATAW +: DATAW] = 64'h3000 + 64'(c);
      @(negedge clk);
      checks++; if (req_ready_in !== (NUM_REQS'(1) << order[c])) begin errors++; $display("FAIL b2b_grant%0d: got %b expected %b", c, req_ready_in, NUM_REQS'(1) << order[c]); end
      push_req(order[c], 64'h3000 + 64'(c));
      tick();
    end
    req_valid_in   = '0;
    rsp_ready_out  = 4'b0111;
    unit_rsp_valid = 1'b1;
    unit_rsp_tag   = 2'd3;
    unit_rsp_data  = 64'hDEAD_0003;
    @(negedge clk);
    checks++; if (unit_rsp_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_accept: got %b expected 1", unit_rsp_ready); end
    push_rsp(4'b1000, 64'hDEAD_0003);
    tick();
    unit_rsp_tag  = 2'd0;
    unit_rsp_data = 64'hBEEF_0000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid_out !== 4'b1000 || rsp_data_out !== 64'hDEAD_0003) begin errors++; $display("FAIL b2b_hold%0d: got v=%b data=%h expected 1000/dead0003", c, rsp_valid_out, rsp_data_out); end
      checks++; if (unit_rsp_ready !== 1'b0) begin errors++; $display("FAIL b2b_backpressure%0d: got %b expected 0", c, unit_rsp_ready); end
      tick();
    end
    rsp_ready_out = '1;
    @(negedge clk);
    checks++; if (unit_rsp_ready !== 1'b1) begin errors++; $display("FAIL b2b_release: got %b expected 1", unit_rsp_ready); end
    push_rsp(4'b0001, 64'hBEEF_0000);
    tick();
    unit_rsp_tag  = 2'd3;
    unit_rsp_data = 64'hCAFE_0003;
    @(negedge clk);
    checks++; if (rsp_valid_out !== 4'b0001 || unit_rsp_ready !== 1'b1) begin errors++; $display("FAIL b2b_second: got v=%b rdy=%b expected 0001/1", rsp_valid_out, unit_rsp_ready); end
    push_rsp(4'b1000, 64'hCAFE_0003);
    tick();
    unit_rsp_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid_out !== 4'b1000) begin errors++; $display("FAIL b2b_third: got %b expected 1000", rsp_valid_out); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid_out !== '0 || pending_count !== '0) begin errors++; $display("FAIL b2b_empty: got v=%b pend=%0d expected 0000/0", rsp_valid_out, pending_count); end
    tick();
  endtask

  // Requesters 1 and 3 continuously valid
  task automatic test_arbitration();
    int exp_g;
    apply_reset();
    unit_req_ready = 1'b1;
    req_valid_in   = 4'b1010;
    req_data_in[1*DATAW +: DATAW] = 64'h5101;
    req_data_in[3*DATAW +: DATAW] = 64'h5103;
    for (int c = 0; c < 4; c++) begin
`ifdef VX_DIV_SHARE_RR_EN
      exp_g = (c % 2 == 0) ? 1 : 3;
`else
      exp_g = 1;
`endif
      @(negedge clk);
      checks++; if (req_ready_in !== (NUM_REQS'(1) << exp_g)) begin errors++; $display("FAIL arb_grant%0d: got %b expected %b", c, req_ready_in, NUM_REQS'(1) << exp_g); end
      push_req(exp_g, (exp_g == 1) ? 64'h5101 : 64'h5103);
      tick();
    end
    req_valid_in = '0;
    repeat (2) tick();
  endtask

  // Asynchronous reset with three operations outstanding
  task automatic test_reset_mid();
    apply_reset();
    unit_req_ready = 1'b1;
    req_valid_in   = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      req_data_in[2*DATAW +: DATAW] = 64'h6000 + 64'(c);
      @(negedge clk);
      checks++; if (req_ready_in !== 4'b0100) begin errors++; $display("FAIL mid_grant%0d: got %b expected 0100", c, req_ready_in); end
      push_req(2, 64'h6000 + 64'(c));
      tick();
    end
    req_valid_in   = '0;
    unit_req_ready = 1'b0;
    rsp_ready_out  = '0;
    unit_rsp_valid = 1'b1;
    unit_rsp_tag   = 2'd1;
    unit_rsp_data  = 64'h6666;
    tick();
    unit_rsp_valid = 1'b0;
    @(negedge clk);
    checks++; if (pending_count !== CNTW'(3) || rsp_valid_out !== 4'b0010 || unit_req_valid !== 1'b1) begin errors++; $display("FAIL mid_before: got pend=%0d rspv=%b reqv=%b expected 3/0010/1", pending_count, rsp_valid_out, unit_req_valid); end
    #2 reset = 1'b1;
    req_q.delete();
    rsp_q.delete();
    #1;
    checks++; if (unit_req_valid !== 1'b0 || rsp_valid_out !== '0 || pending_count !== '0) begin errors++; $display("FAIL mid_async: got reqv=%b rspv=%b pend=%0d expected 0/0000/0", unit_req_valid, rsp_valid_out, pending_count); end
    checks++; if (unit_rsp_ready !== 1'b1 || unit_req_data !== '0 || rsp_data_out !== '0) begin errors++; $display("FAIL mid_async_data: got rdy=%b reqd=%h rspd=%h expected 1/0/0", unit_rsp_ready, unit_req_data, rsp_data_out); end
    req_valid_in = '1;
    for (int i = 0; i < NUM_REQS; i++) req_data_in[i*DATAW +: DATAW] = 64'h7000 + 64'(i);
    unit_req_ready = 1'b1;
    rsp_ready_out  = '1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready_in !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready_in); end
    push_req(0, 64'h7000);
    tick();
    req_valid_in = '0;
    repeat (2) tick();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_fill();
    test_stall();
    test_credit();
    test_back_to_back();
    test_arbitration();
    test_reset_mid();
    checks++;
    if (req_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got req_q=%0d rsp_q=%0d expected 0/0", req_q.size(), rsp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vx_div_share_ctrl.md
# vx_div_share_ctrl

Arbiter and sequencer that shares one iterative divide unit among `NUM_REQS` ALU blocks. Requests enter from each block's execute path and are serialized onto the unit's request port. The number of operations in flight is bounded by a credit counter. Responses carry a requester tag and are steered back to the issuing block through a registered output stage.

## Interface
Parameters:
- `NUM_REQS`, 4: number of requesting ALU blocks (≥1).
- `DATAW`, 64: request/response payload width.
- `MAX_PENDING`, 4: maximum operations accepted but not yet delivered back (≥1).
- Derived: `TAGW = max(1, clog2(NUM_REQS))`, `CNTW = clog2(MAX_PENDING+1)`.

Ports:
- `clk`  in  1  clock; one clock domain, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid_in`  in  NUM_REQS  per-requester request valid.
- `req_data_in`  in  NUM_REQS*DATAW  per-requester payload, requester i at [i*DATAW +: DATAW].
- `req_ready_in`  out  NUM_REQS  per-requester accept.
- `unit_req_valid`  out  1  request to divide unit.
- `unit_req_data`  out  DATAW  payload to unit.
- `unit_req_tag`  out  TAGW  requester index; the unit returns it unchanged.
- `unit_req_ready`  in  1  unit accepts request.
- `unit_rsp_valid`  in  1  unit result valid.
- `unit_rsp_data`  in  DATAW  result payload.
- `unit_rsp_tag`  in  TAGW  result's requester index.
- `unit_rsp_ready`  out  1  controller accepts result.
- `rsp_valid_out`  out  NUM_REQS  one-hot result valid toward requester.
- `rsp_data_out`  out  DATAW  shared result bus.
- `rsp_ready_out`  in  NUM_REQS  per-requester result accept.
- `pending_count`  out  CNTW  current credit usage (debug/perf).

## Operation
- **Request stage.** One-entry elastic register (`rb_valid`, `rb_data`, `rb_tag`) drives the `unit_req_*` outputs.
  - Stage can load when `!rb_valid || unit_req_ready`.
- **Credit.** `credit_ok = pending_count < MAX_PENDING`.
- **Arbitration.**
  - Candidates are requesters with `req_valid_in` set.
  - Grant one when the stage can load and `credit_ok` holds.
  - `req_ready_in[g]` = 1 only for the granted index; all other bits are 0.
  - A requester never sees ready without a grant.
- **Load.** On accept, the stage loads the granted data with tag g.
- **Pending counter.**
  - +1 on request accept (`req_valid_in[g] && req_ready_in[g]`).
  - −1 on result delivery (`rsp_valid_out[t] && rsp_ready_out[t]`).
  - Both in the same cycle: no change.
  - Never exceeds `MAX_PENDING`; never underflows. Underflow is an assertion error.
- **Response stage.** One-entry register (`ob_valid`, `ob_data`, `ob_tag`).
  - `unit_rsp_ready = !ob_valid || rsp_ready_out[ob_tag]`.
  - On `unit_rsp_valid && unit_rsp_ready`, load data and tag.
  - `rsp_valid_out = ob_valid ? onehot(ob_tag) : 0`.
  - `rsp_data_out = ob_data`.
  - A stalled requester blocks the unit's responses (in-order unit).
- **Reset value of every output.**
  - Asserted by reset:
    - `unit_req_valid` = 0
    - `rsp_valid_out` = 0
    - `pending_count` = 0
  - `req_ready_in` is combinational from these and from `req_valid_in`. It is 0 only when no requester is valid. Immediately after reset, with any requester valid, the grant drives `req_ready_in[g]` = 1.
  - `unit_req_data`, `unit_req_tag`, `rsp_data_out` = 0.
  - `unit_rsp_ready` = 1.
  - Round-robin pointer = 0.
- **Reset mid-operation.** All in-flight state is discarded. The divide unit must be reset in the same cycle; this is a system-level requirement.

## Timing
- Request latency: accepted at edge N → `unit_req_valid` at cycle N+1.
- Full throughput: one request/cycle when `unit_req_ready` stays high and credits remain.
- Response latency: unit result accepted at edge M → `rsp_valid_out` at cycle M+1.
- Back-to-back results:
  - One per cycle while the target requester is ready.
  - Stage drains and refills in the same cycle.
- `unit_req_valid`/data/tag hold stable while `unit_req_ready`=0.
- Credit full (`pending_count == MAX_PENDING`): `req_ready_in` all 0.
- Credit freed by delivery at edge K: a new grant is possible in cycle K+1. There is no same-cycle bypass.
- Pointer update: after a grant to g, the pointer becomes `(g+1) mod NUM_REQS` at the next edge. The pointer is unchanged when there is no grant.
- `NUM_REQS=1`: pointer constant 0, tag 0.

## Configuration
- `VX_DIV_SHARE_RR_EN` defined:
  - Round-robin grant.
  - Search starts at the pointer and proceeds upward, wrapping at `NUM_REQS`.
- Undefined:
  - Fixed priority: the lowest valid index wins.
  - Pointer register is removed.
  - All other behaviour is identical.

## Test plan
- Reset with all 4 requesters valid, unit always ready, `MAX_PENDING`=4 (RR_EN) → grants 0,1,2,3 on consecutive cycles; `unit_req_tag` 0,1,2,3 from cycle 1; `pending_count` reaches 4; no further ready.
- Unit ready low 5 cycles with a buffered request (data 0xABCD, tag 2) → `unit_req_*` held stable all 5 cycles; exactly one transfer once ready rises.
- Credit full, then result tag 1 delivered with `rsp_ready_out[1]`=1 at edge K → `pending_count` drops to 3; next grant in cycle K+1; simultaneous accept + delivery keeps the count constant.
- Results tags 3,0,3 back-to-back with requester 3 ready low 2 cycles → `rsp_valid_out`=4'b1000 held, `unit_rsp_ready`=0 during the stall, then order 3,0,3 delivered with data intact.
- RR_EN undefined, requesters 1 and 3 continuously valid → requester 1 granted every cycle, requester 3 starved; with RR_EN they alternate 1,3,1,3.
- Async reset asserted mid-stream with 3 pending → outputs return to reset values immediately; `pending_count`=0; first grant after release goes to requester 0.
